queue_mag_window: RTL and testbench
===================================

// Module: queue_mag_window
// PURPOSE
//  Multichannel sliding-window magnitude buffer for the LED/level-meter path.
//  Stores |sample| for NCH channels (lft/rht) in per-channel circular RAM banks of
//  2**WIN_LOG2 entries and keeps a running sum per channel.
//  Outputs a per-channel window average on every accepted sample once the window is full.
//  Optionally streams the whole window (oldest->newest) after each sample.
// PARAMETERS
//  DATA_W    16  sample width (two's complement in, magnitude stored)
//  WIN_LOG2  10  log2 window depth; WIN = 2**WIN_LOG2 entries per channel
//  NCH       2   channel count; channel c occupies bits [c*DATA_W +: DATA_W]
// PORTS
//  clk        in   1                clock, all logic on rising edge
//  rst_n      in   1                asynchronous active-low reset
//  wrt_smpl   in   1                one-cycle strobe: new_smpl valid, accept all channels
//  new_smpl   in   NCH*DATA_W       packed input samples
//  full       out  1                window holds WIN valid samples
//  avg_vld    out  1                one-cycle pulse: avg updated
//  avg        out  NCH*DATA_W       packed per-channel window average (magnitude)
//  sequencing out  1                high while window readout streams
//  smpl_vld   out  1                smpl_out beat valid
//  smpl_out   out  NCH*DATA_W       packed readout beat
//  ovr        out  1                sticky: readout trigger dropped
// BEHAVIOUR
//  - Reset: wr_ptr=0, fill count=0, sums=0, full=0, avg_vld=0, avg=0, sequencing=0,
//    smpl_vld=0, smpl_out=0, ovr=0. RAM contents not cleared; stale data unused.
//  - Magnitude: mag = x[DATA_W-1] ? ~x : x (0x8000->0x7FFF, 0xFFFF->0x0000).
//  - Stage 0 (cycle with wrt_smpl=1): write mag to wr_ptr in every bank. Read the old
//    entry at wr_ptr in the same cycle (read-before-write). wr_ptr++ wraps WIN-1 -> 0.
//  - Stage 1: RAM rdata (oldest) valid. Stage 2: sum += mag - (full ? oldest : 0).
//  - Sum width DATA_W+WIN_LOG2, never overflows; avg = sum >> WIN_LOG2 (truncate).
//  - avg_vld pulses exactly 2 cycles after the wrt_smpl cycle, only when full was
//    already 1 or becomes 1 with this sample. During fill: sums update, avg holds.
//  - full sets when the WIN-th sample since reset is written; stays 1 until reset.
//  - wrt_smpl may be asserted every cycle; pipeline is fully throughput-1.
//  - Reset mid-operation: pipeline aborted, fill restarts; no avg_vld from
//    in-flight samples.
// CONFIGURATION
//  QUEUE_READOUT_EN defined:
//   - FSM IDLE/READOUT. Trigger = avg_vld. IDLE+trigger -> READOUT.
//   - Latch P = wr_ptr (oldest). Read P+i for i=0..WIN-1.
//   - smpl_vld/smpl_out 1 cycle after each read. sequencing=1 from first read to last beat.
//   - After WIN beats -> IDLE.
//   - Writes during READOUT accepted. Slot P+j is read before or in the cycle it is
//     rewritten (read-before-write), so the stream is the trigger-time snapshot.
//   - Trigger while READOUT: dropped; ovr<=1 (sticky until reset); stream continues.
//  QUEUE_READOUT_EN undefined:
//   - No FSM or readout port. sequencing, smpl_vld, smpl_out, ovr tied 0.
// TESTING (bench uses WIN_LOG2=3, NCH=2, DATA_W=16)
//  - Reset, 7 strobes of ch0=0x0010 -> full=0, no avg_vld. 8th strobe -> full=1;
//    avg_vld 2 cycles later; avg ch0=0x0010.
//  - Full window of 0x0010, then 8 strobes of ch0=0xFFF0 (mag 0x000F) -> avg steps
//    0x0010,...; final avg=0x000F.
//  - ch1 alternating 0x8000/0x7FFF for 8 strobes -> ch1 avg=0x7FFF.
//    Ch0 unaffected by ch1 data.
//  - wrt_smpl held high 20 cycles with ramp 0..19 on ch0 -> avg_vld high every cycle
//    once full; last avg=(12+..+19)>>3=0x000F.
//  - Assert rst_n=0 between strobe and avg_vld -> no avg_vld. After release: full=0,
//    avg=0, 8 new strobes needed.
//  - [QUEUE_READOUT_EN] full window 1..8, strobe 9 -> smpl_out beats 2..9,
//    sequencing 8 cycles. Strobe mid-stream -> stream unchanged, ovr=1.

Source files
------------

// File: rtl/queue_mag_window.sv
// queue_mag_window: per-channel sliding-window |sample| buffer with running-sum average.
// Optional oldest->newest window readout stream is built when QUEUE_READOUT_EN is defined.

module queue_mag_window_ch #(
   parameter int DATA_W   = 16,
   parameter int WIN_LOG2 = 10
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en_i,
   input  logic [WIN_LOG2-1:0] wr_addr_i,
   input  logic [DATA_W-1:0]   smpl_i,
   input  logic                s1_vld_i,
   input  logic                s1_sub_i,
   input  logic                s1_fire_i,
   output logic [DATA_W-1:0]   avg_o
`ifdef QUEUE_READOUT_EN
   ,
   input  logic                rd_en_i,
   input  logic [WIN_LOG2-1:0] rd_addr_i,
   output logic [DATA_W-1:0]   rd_data_o
`endif
);
   localparam int WIN   = 1 << WIN_LOG2;
   localparam int SUM_W = DATA_W + WIN_LOG2;

   logic [DATA_W-1:0] mem [WIN];
   logic [DATA_W-1:0] mag;
   logic [DATA_W-1:0] mag_q, old_q;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [DATA_W-1:0] avg_q;

   // One's-complement style fold keeps the magnitude within DATA_W bits.
   assign mag = smpl_i[DATA_W-1] ? ~smpl_i : smpl_i;

   always_ff @(posedge clk) begin
      if (wr_en_i) mem[wr_addr_i] <= mag;
   end

   // Old entry is captured in the same cycle it is overwritten.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_q <= '0;
         old_q <= '0;
      end else if (wr_en_i) begin
         mag_q <= mag;
         old_q <= mem[wr_addr_i];
      end
   end

   always_comb begin
      sum_d = sum_q + SUM_W'(mag_q);
      if (s1_sub_i) sum_d = sum_d - SUM_W'(old_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         avg_q <= '0;
      end else if (s1_vld_i) begin
         sum_q <= sum_d;
         if (s1_fire_i) avg_q <= sum_d[SUM_W-1:WIN_LOG2];
      end
   end

   assign avg_o = avg_q;

`ifdef QUEUE_READOUT_EN
   logic [DATA_W-1:0] rd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       rd_q <= '0;
      else if (rd_en_i) rd_q <= mem[rd_addr_i];
   end

   assign rd_data_o = rd_q;
`endif
endmodule

module queue_mag_window #(
   parameter int DATA_W   = 16,
   parameter int WIN_LOG2 = 10,
   parameter int NCH      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wrt_smpl,
   input  logic [NCH*DATA_W-1:0] new_smpl,
   output logic                  full,
   output logic                  avg_vld,
   output logic [NCH*DATA_W-1:0] avg,
   output logic                  sequencing,
   output logic                  smpl_vld,
   output logic [NCH*DATA_W-1:0] smpl_out,
   output logic                  ovr
);
   localparam int WIN = 1 << WIN_LOG2;

   logic [WIN_LOG2-1:0] wr_ptr_q;
   logic                full_q;
   logic                last_slot;
   logic                s1_sub_q, s1_fire_q;
   // [0]: stage-1 sum update, [1]: avg_vld
   logic [1:0]          vld_pipe_q;

   // Until full, wr_ptr doubles as the fill count.
   assign last_slot = &wr_ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         full_q     <= 1'b0;
         s1_sub_q   <= 1'b0;
         s1_fire_q  <= 1'b0;
         vld_pipe_q <= '0;
      end else begin
         vld_pipe_q <= {vld_pipe_q[0] & s1_fire_q, wrt_smpl};
         if (wrt_smpl) begin
            wr_ptr_q  <= wr_ptr_q + WIN_LOG2'(1);
            s1_sub_q  <= full_q;
            s1_fire_q <= full_q | last_slot;
            if (last_slot) full_q <= 1'b1;
         end
      end
   end

   assign full    = full_q;
   assign avg_vld = vld_pipe_q[1];

`ifdef QUEUE_READOUT_EN
   typedef enum logic {ST_IDLE, ST_READOUT} st_e;

   st_e                 st_q, st_d;
   logic [WIN_LOG2-1:0] base_q, base_d;
   logic [WIN_LOG2:0]   idx_q, idx_d;
   logic                ovr_q, ovr_d;
   logic                smpl_vld_q;
   logic                rd_en;
   logic [WIN_LOG2-1:0] rd_addr;

   // Slot 0 is read in the trigger cycle itself so that any write landing on the
   // oldest slot in that cycle still sees the pre-write value.
   always_comb begin
      st_d    = st_q;
      base_d  = base_q;
      idx_d   = idx_q;
      ovr_d   = ovr_q;
      rd_en   = 1'b0;
      rd_addr = base_q + idx_q[WIN_LOG2-1:0];
      unique case (st_q)
         ST_IDLE: begin
            if (avg_vld) begin
               rd_en   = 1'b1;
               rd_addr = wr_ptr_q;
               base_d  = wr_ptr_q;
               idx_d   = (WIN_LOG2+1)'(1);
               st_d    = ST_READOUT;
            end
         end
         ST_READOUT: begin
            if (avg_vld) ovr_d = 1'b1;
            if (idx_q == (WIN_LOG2+1)'(WIN)) begin
               st_d = ST_IDLE;
            end else begin
               rd_en = 1'b1;
               idx_d = idx_q + (WIN_LOG2+1)'(1);
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q       <= ST_IDLE;
         base_q     <= '0;
         idx_q      <= '0;
         ovr_q      <= 1'b0;
         smpl_vld_q <= 1'b0;
      end else begin
         st_q       <= st_d;
         base_q     <= base_d;
         idx_q      <= idx_d;
         ovr_q      <= ovr_d;
         smpl_vld_q <= rd_en;
      end
   end

   assign sequencing = (st_q == ST_READOUT);
   assign smpl_vld   = smpl_vld_q;
   assign ovr        = ovr_q;
`else
   assign sequencing = 1'b0;
   assign smpl_vld   = 1'b0;
   assign smpl_out   = '0;
   assign ovr        = 1'b0;
`endif

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      queue_mag_window_ch #(
         .DATA_W   (DATA_W),
         .WIN_LOG2 (WIN_LOG2)
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .wr_en_i   (wrt_smpl),
         .wr_addr_i (wr_ptr_q),
         .smpl_i    (new_smpl[c*DATA_W +: DATA_W]),
         .s1_vld_i  (vld_pipe_q[0]),
         .s1_sub_i  (s1_sub_q),
         .s1_fire_i (s1_fire_q),
         .avg_o     (avg[c*DATA_W +: DATA_W])
`ifdef QUEUE_READOUT_EN
         ,
         .rd_en_i   (rd_en),
         .rd_addr_i (rd_addr),
         .rd_data_o (smpl_out[c*DATA_W +: DATA_W])
`endif
      );
   end
endmodule

// File: tb/tb_queue_mag_window.sv
// Bench for queue_mag_window at WIN_LOG2=3, NCH=2: vector table, corner sequences and a
// randomized run checked every cycle against a queue-based window model.
module tb_queue_mag_window;
   localparam int DW  = 16;
   localparam int WL  = 3;
   localparam int NCH = 2;
   localparam int WIN = 1 << WL;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              wrt_smpl = 1'b0;
   logic [NCH*DW-1:0] new_smpl = '0;
   logic              full, avg_vld, sequencing, smpl_vld, ovr;
   logic [NCH*DW-1:0] avg, smpl_out;

   queue_mag_window #(.DATA_W(DW), .WIN_LOG2(WL), .NCH(NCH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wrt_smpl   (wrt_smpl),
      .new_smpl   (new_smpl),
      .full       (full),
      .avg_vld    (avg_vld),
      .avg        (avg),
      .sequencing (sequencing),
      .smpl_vld   (smpl_vld),
      .smpl_out   (smpl_out),
      .ovr        (ovr)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // reference model state
   typedef struct { int due; logic [31:0] avg; } ev_t;
   ev_t         ev_q[$];
   logic [15:0] h0[$], h1[$];
   int          n_acc = 0;
   bit          exp_full = 1'b0;
   logic [31:0] exp_avg = '0;
`ifdef QUEUE_READOUT_EN
   logic [15:0] snap0[$], snap1[$];
   int          rd_start = -100, rd_end = -100;
   bit          ovr_exp = 1'b0, ovr_pend = 1'b0;
`endif

   typedef struct {
      bit          w;
      logic [31:0] smp;
      bit          efull;
      bit          evld;
      logic [31:0] eavg;
   } vec_t;
   vec_t tbl[30];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [15:0] mag16(input logic [15:0] x);
      int v;
      v = int'($signed(x));
      return 16'((v < 0) ? (-v - 1) : v);
   endfunction

   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 7))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'hFFFF;
         3:       return 16'h0000;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic model_clear();
      ev_q.delete(); h0.delete(); h1.delete();
      n_acc = 0; exp_full = 1'b0; exp_avg = '0;
`ifdef QUEUE_READOUT_EN
      rd_start = -100; rd_end = -100; ovr_exp = 1'b0; ovr_pend = 1'b0;
`endif
   endtask

   task automatic model_accept(input logic [31:0] s);
      int s0, s1;
      h0.push_back(mag16(s[15:0]));
      h1.push_back(mag16(s[31:16]));
      if (h0.size() > WIN) begin
         void'(h0.pop_front());
         void'(h1.pop_front());
      end
      n_acc++;
      exp_full = (n_acc >= WIN);
      if (exp_full) begin
         s0 = 0; s1 = 0;
         foreach (h0[i]) begin
            s0 += int'(h0[i]);
            s1 += int'(h1[i]);
         end
         ev_q.push_back('{cyc + 1, {16'(s1 / WIN), 16'(s0 / WIN)}});
      end
   endtask

   task automatic check_cycle();
      bit ev;
      ev = 1'b0;
      if (ev_q.size() > 0 && ev_q[0].due == cyc) begin
         ev = 1'b1;
         exp_avg = ev_q[0].avg;
         void'(ev_q.pop_front());
      end
      chk("full", 64'(full), 64'(exp_full));
      chk("avg_vld", 64'(avg_vld), 64'(ev));
      chk("avg", 64'(avg), 64'(exp_avg));
`ifdef QUEUE_READOUT_EN
      ovr_exp  = ovr_exp | ovr_pend;
      ovr_pend = 1'b0;
      if (ev) begin
         if (cyc <= rd_end) ovr_pend = 1'b1;
         else begin
            rd_start = cyc; rd_end = cyc + WIN;
            snap0 = h0; snap1 = h1;
         end
      end
      if (cyc > rd_start && cyc <= rd_end) begin
         chk("sequencing", 64'(sequencing), 64'd1);
         chk("smpl_vld", 64'(smpl_vld), 64'd1);
         chk("smpl_out", 64'(smpl_out),
             64'({snap1[cyc - rd_start - 1], snap0[cyc - rd_start - 1]}));
      end else begin
         chk("sequencing", 64'(sequencing), 64'd0);
         chk("smpl_vld", 64'(smpl_vld), 64'd0);
      end
      chk("ovr", 64'(ovr), 64'(ovr_exp));
`else
      chk("readout_tied", 64'({smpl_out, sequencing, smpl_vld, ovr}), 64'd0);
`endif
   endtask

   task automatic step(input bit w, input logic [31:0] smp);
      wrt_smpl = w;
      new_smpl = smp;
      @(posedge clk); #1;
      cyc++;
      wrt_smpl = 1'b0;
      if (w) model_accept(smp);
      check_cycle();
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      wrt_smpl = 1'b0;
      model_clear();
      @(posedge clk); #1;
      cyc++;
      chk("rst_out", 64'({full, avg_vld, sequencing, smpl_vld, ovr}), 64'd0);
      chk("rst_avg", 64'(avg), 64'd0);
      chk("rst_smpl_out", 64'(smpl_out), 64'd0);
      @(posedge clk); #1;
      cyc++;
      rst_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          nv, nb, nseq;
      logic [15:0] beat[8];
      logic [15:0] c1;

      // directed table: fill, decay to 0xF, ch1 alternating extremes
      for (int i = 0; i < 30; i++) begin
         tbl[i].w     = (i < 8) || (i >= 10 && i < 18) || (i >= 20 && i < 28);
         tbl[i].smp   = (i < 8)  ? 32'h0000_0010 :
                        (i < 18) ? 32'h0000_FFF0 :
                        {((i % 2) == 0) ? 16'h8000 : 16'h7FFF, 16'hFFF0};
         tbl[i].efull = (i >= 7);
         tbl[i].evld  = (i == 8) || (i >= 11 && i <= 18) || (i >= 21 && i <= 28);
         c1 = (i <= 20) ? 16'h0 : 16'((((i > 28) ? 28 : i) - 20) * 4096 - 1);
         tbl[i].eavg  = {c1, (i < 8) ? 16'h0 : (i <= 10) ? 16'h0010 : 16'h000F};
      end

      apply_reset();
      for (int i = 0; i < 30; i++) begin
         step(tbl[i].w, tbl[i].smp);
         chk($sformatf("tbl%0d_full", i), 64'(full), 64'(tbl[i].efull));
         chk($sformatf("tbl%0d_vld", i), 64'(avg_vld), 64'(tbl[i].evld));
         chk($sformatf("tbl%0d_avg", i), 64'(avg), 64'(tbl[i].eavg));
      end

      // back-to-back ramp
      apply_reset();
      nv = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 32'(i));
         if (avg_vld) nv++;
      end
      step(1'b0, 32'h0);
      if (avg_vld) nv++;
      chk("ramp_vld_count", 64'(nv), 64'd13);
      chk("ramp_last_avg", 64'(avg[15:0]), 64'h000F);

      // reset between strobe and avg_vld
      step(1'b1, 32'h0005_0005);
      apply_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0);
      chk("rst_mid_full", 64'(full), 64'd0);
      chk("rst_mid_avg", 64'(avg), 64'd0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 32'h0003_0003);
         if (i == 6) chk("refill7_full", 64'(full), 64'd0);
      end
      chk("refill8_full", 64'(full), 64'd1);
      step(1'b0, 32'h0);
      chk("refill_avg", 64'(avg), 64'h0003_0003);

`ifdef QUEUE_READOUT_EN
      // readout snapshot with a write and a dropped trigger mid-stream
      apply_reset();
      for (int v = 1; v <= 8; v++) step(1'b1, 32'(v));
      for (int i = 0; i < 12; i++) step(1'b0, 32'h0);
      chk("ro_ovr_before", 64'(ovr), 64'd0);
      nb = 0; nseq = 0;
      step(1'b1, 32'd9);
      for (int k = 0; k < 14; k++) begin
         step(k == 2, 32'd10);
         if (smpl_vld) begin
            if (nb < 8) beat[nb] = smpl_out[15:0];
            nb++;
         end
         if (sequencing) nseq++;
      end
      chk("ro_beats", 64'(nb), 64'd8);
      chk("ro_seq_cycles", 64'(nseq), 64'd8);
      for (int i = 0; i < 8; i++) chk($sformatf("ro_beat%0d", i), 64'(beat[i]), 64'(i + 2));
      chk("ro_ovr_after", 64'(ovr), 64'd1);
`endif

      // randomized: sparse then dense traffic, one reset in the middle
      apply_reset();
      for (int i = 0; i < 450; i++) begin
         if (i == 300) apply_reset();
         if (i < 150) step($urandom_range(0, 9) == 0, {rnd16(), rnd16()});
         else         step($urandom_range(0, 3) != 0, {rnd16(), rnd16()});
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
